ahfp_pipeline_arbiter: RTL and testbench

Round-robin scheduler sharing one fixed-latency, non-stalling floating-point pipeline (ahfp_pipeline_buffer style, STAGES deep) between two requesters. Issues at most one operation per cycle and tracks in-flight tags in a STAGES-deep valid/ID shift register. Returns each result tagged with its requester ID. Drain FSM quiesces the pipeline for reconfiguration or sim checkpoints.

---
 rtl/ahfp_arb_pkg.sv | 18 +
 rtl/ahfp_tag_delay.sv | 34 +++
 rtl/ahfp_pipeline_arbiter.sv | 146 ++++++++++++++
 tb/tb_ahfp_pipeline_arbiter.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ahfp_arb_pkg.sv
// rtl/ahfp_arb_pkg.sv - shared types for the FP pipeline arbiter
package ahfp_arb_pkg;

   typedef enum logic [1:0] {
      ST_RUN    = 2'd0,
      ST_DRAIN  = 2'd1,
      ST_HALTED = 2'd2
   } arb_state_t;

   typedef struct packed {
      logic valid;
      logic id;
   } arb_tag_t;

   localparam logic REQ0 = 1'b0;
   localparam logic REQ1 = 1'b1;

endpackage

// File: rtl/ahfp_tag_delay.sv
// rtl/ahfp_tag_delay.sv - STAGES-deep in-flight tag shift register
module ahfp_tag_delay
   import ahfp_arb_pkg::*;
#(
   parameter int STAGES = 10
) (
   input  logic     clk,
   input  logic     reset,
   input  arb_tag_t tag_in,
   output arb_tag_t tag_out,
   output logic     any_valid
);

   arb_tag_t stage [STAGES];

   // shift one stage per cycle; reset discards everything in flight
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < STAGES; i++) stage[i] <= '0;
      end else begin
         stage[0] <= tag_in;
         for (int i = 1; i < STAGES; i++) stage[i] <= stage[i-1];
      end
   end

   // occupancy summary used by the drain FSM
   always_comb begin
      any_valid = 1'b0;
      for (int i = 0; i < STAGES; i++) any_valid = any_valid | stage[i].valid;
   end

   assign tag_out = stage[STAGES-1];

endmodule

// File: rtl/ahfp_pipeline_arbiter.sv
// rtl/ahfp_pipeline_arbiter.sv - round-robin issue to a shared FP pipeline (optional stats: AHFP_ARB_STATS_EN)
module ahfp_pipeline_arbiter
   import ahfp_arb_pkg::*;
#(
   parameter int STAGES = 10,
   parameter int WIDTH  = 32,
   parameter int CNT_W  = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             req0_valid,
   output logic             req0_ready,
   input  logic [WIDTH-1:0] req0_a,
   input  logic [WIDTH-1:0] req0_b,
   input  logic             req1_valid,
   output logic             req1_ready,
   input  logic [WIDTH-1:0] req1_a,
   input  logic [WIDTH-1:0] req1_b,
   output logic             fpu_valid,
   output logic [WIDTH-1:0] fpu_a,
   output logic [WIDTH-1:0] fpu_b,
   input  logic [WIDTH-1:0] fpu_result,
   output logic             res_valid,
   output logic             res_id,
   output logic [WIDTH-1:0] res_data,
   input  logic             drain_req,
   output logic             drain_done,
   output logic             busy
`ifdef AHFP_ARB_STATS_EN
   ,
   output logic [CNT_W-1:0] stat_issue0,
   output logic [CNT_W-1:0] stat_issue1,
   output logic [CNT_W-1:0] stat_conflict
`endif
);

   arb_state_t state, state_next;
   logic       rr_ptr;       // requester favoured on the next conflict
   logic       accept;
   logic       grant_id;
   logic       fpu_id;
   logic       tags_busy;
   arb_tag_t   tag_out;

   // state register
   always_ff @(posedge clk) begin
      if (reset) state <= ST_RUN;
      else       state <= state_next;
   end

   // next state, grant and drain status
   always_comb begin
      state_next = state;
      req0_ready = 1'b0;
      req1_ready = 1'b0;
      drain_done = 1'b0;
      case (state)
         ST_RUN: begin
            if (req0_valid && req1_valid) begin
               req0_ready = (rr_ptr == REQ0);
               req1_ready = (rr_ptr == REQ1);
            end else begin
               req0_ready = req0_valid;
               req1_ready = req1_valid;
            end
            if (drain_req) state_next = ST_DRAIN;
         end
         ST_DRAIN: begin
            if (!drain_req)                   state_next = ST_RUN;
            else if (!tags_busy && !fpu_valid) state_next = ST_HALTED;
         end
         ST_HALTED: begin
            drain_done = 1'b1;
            if (!drain_req) state_next = ST_RUN;
         end
         default: state_next = ST_RUN;
      endcase
   end

   assign accept   = (req0_valid && req0_ready) || (req1_valid && req1_ready);
   assign grant_id = req1_ready ? REQ1 : REQ0;

   // issue register; operands hold when nothing is accepted
   always_ff @(posedge clk) begin
      if (reset) begin
         fpu_valid <= 1'b0;
         fpu_id    <= REQ0;
         fpu_a     <= '0;
         fpu_b     <= '0;
         rr_ptr    <= REQ0;
      end else begin
         fpu_valid <= accept;
         if (accept) begin
            fpu_id <= grant_id;
            fpu_a  <= (grant_id == REQ1) ? req1_a : req0_a;
            fpu_b  <= (grant_id == REQ1) ? req1_b : req0_b;
            rr_ptr <= ~grant_id;
         end
      end
   end

   // the issue register is tag stage 0; the delay line lines the tag up with fpu_result
   ahfp_tag_delay #(.STAGES(STAGES)) u_tag_delay (
      .clk       (clk),
      .reset     (reset),
      .tag_in    ({fpu_valid, fpu_id}),
      .tag_out   (tag_out),
      .any_valid (tags_busy)
   );

   // capture the pipeline output only when its tag says it is real
   always_ff @(posedge clk) begin
      if (reset) begin
         res_valid <= 1'b0;
         res_id    <= REQ0;
         res_data  <= '0;
      end else begin
         res_valid <= tag_out.valid;
         if (tag_out.valid) begin
            res_id   <= tag_out.id;
            res_data <= fpu_result;
         end
      end
   end

   assign busy = fpu_valid | tags_busy | res_valid;

`ifdef AHFP_ARB_STATS_EN
   // saturating accept/conflict counters
   always_ff @(posedge clk) begin
      if (reset) begin
         stat_issue0   <= '0;
         stat_issue1   <= '0;
         stat_conflict <= '0;
      end else begin
         if (req0_valid && req0_ready && stat_issue0 != '1)
            stat_issue0 <= stat_issue0 + 1'b1;
         if (req1_valid && req1_ready && stat_issue1 != '1)
            stat_issue1 <= stat_issue1 + 1'b1;
         if (state == ST_RUN && req0_valid && req1_valid && stat_conflict != '1)
            stat_conflict <= stat_conflict + 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_ahfp_pipeline_arbiter.sv
// tb/tb_ahfp_pipeline_arbiter.sv - self-checking bench for ahfp_pipeline_arbiter
module tb_ahfp_pipeline_arbiter;

   localparam int STAGES = 10;
   localparam int WIDTH  = 32;
`ifdef AHFP_ARB_STATS_EN
   localparam int CNT_W  = 4;
`else
   localparam int CNT_W  = 16;
`endif

   logic             clk;
   logic             reset;
   logic             req0_valid, req0_ready, req1_valid, req1_ready;
   logic [WIDTH-1:0] req0_a, req0_b, req1_a, req1_b;
   logic             fpu_valid;
   logic [WIDTH-1:0] fpu_a, fpu_b, fpu_result;
   logic             res_valid, res_id;
   logic [WIDTH-1:0] res_data;
   logic             drain_req, drain_done, busy;
`ifdef AHFP_ARB_STATS_EN
   logic [CNT_W-1:0] stat_issue0, stat_issue1, stat_conflict;
`endif

   ahfp_pipeline_arbiter #(.STAGES(STAGES), .WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
      .clk        (clk),
      .reset      (reset),
      .req0_valid (req0_valid),
      .req0_ready (req0_ready),
      .req0_a     (req0_a),
      .req0_b     (req0_b),
      .req1_valid (req1_valid),
      .req1_ready (req1_ready),
      .req1_a     (req1_a),
      .req1_b     (req1_b),
      .fpu_valid  (fpu_valid),
      .fpu_a      (fpu_a),
      .fpu_b      (fpu_b),
      .fpu_result (fpu_result),
      .res_valid  (res_valid),
      .res_id     (res_id),
      .res_data   (res_data),
      .drain_req  (drain_req),
      .drain_done (drain_done),
      .busy       (busy)
`ifdef AHFP_ARB_STATS_EN
      ,
      .stat_issue0   (stat_issue0),
      .stat_issue1   (stat_issue1),
      .stat_conflict (stat_conflict)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // fixed-latency pipeline model: result = a + b, STAGES cycles after fpu_a
   logic [WIDTH-1:0] pipe [STAGES];
   always @(posedge clk) begin
      pipe[0] <= fpu_a + fpu_b;
      for (int i = 1; i < STAGES; i++) pipe[i] <= pipe[i-1];
   end
   assign fpu_result = pipe[STAGES-1];

   typedef struct {
      bit               id;
      logic [WIDTH-1:0] data;
      int               cyc;
   } sb_t;

   typedef struct {
      bit v0;
      bit v1;
      bit r0;
      bit r1;
   } vec_t;

   sb_t              sbq[$];
   int               checks, errors, cyc, last_res_cyc;
   bit               pend_fv, chk_rdy, exp_r0, exp_r1;
   logic [WIDTH-1:0] pend_a, pend_b;
   vec_t             vecs[11];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic monitor();
      sb_t e;
      if (reset) begin
         pend_fv = 1'b0;
         return;
      end
      check("fpu_valid", {31'd0, fpu_valid}, {31'd0, pend_fv});
      if (pend_fv) begin
         check("fpu_a", fpu_a, pend_a);
         check("fpu_b", fpu_b, pend_b);
      end
      check("one_ready", {31'd0, req0_ready & req1_ready}, 32'd0);
      if (chk_rdy) begin
         check("req0_ready", {31'd0, req0_ready}, {31'd0, exp_r0});
         check("req1_ready", {31'd0, req1_ready}, {31'd0, exp_r1});
      end
      pend_fv = 1'b0;
      if (req0_valid && req0_ready) begin
         sbq.push_back('{id: 1'b0, data: req0_a + req0_b, cyc: cyc});
         pend_fv = 1'b1; pend_a = req0_a; pend_b = req0_b;
      end
      if (req1_valid && req1_ready) begin
         sbq.push_back('{id: 1'b1, data: req1_a + req1_b, cyc: cyc});
         pend_fv = 1'b1; pend_a = req1_a; pend_b = req1_b;
      end
      if (res_valid) begin
         if (sbq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL res_unexpected actual=1 required=0 (cycle %0d)", cyc);
         end else begin
            e = sbq.pop_front();
            check("res_id", {31'd0, res_id}, {31'd0, e.id});
            check("res_data", res_data, e.data);
            check("latency", cyc, e.cyc + STAGES + 2);
            last_res_cyc = cyc;
         end
      end
   endtask

   task automatic tick();
      @(negedge clk);
      monitor();
      @(posedge clk);
      #1;
      cyc++;
      chk_rdy = 1'b0;
   endtask

   task automatic drive(input bit v0, input bit v1, input bit dr);
      req0_valid = v0; req0_a = $urandom; req0_b = $urandom;
      req1_valid = v1; req1_a = $urandom; req1_b = $urandom;
      drain_req  = dr;
   endtask

   task automatic expect_ready(input bit r0, input bit r1);
      chk_rdy = 1'b1; exp_r0 = r0; exp_r1 = r1;
   endtask

   task automatic do_reset(input int n);
      reset = 1'b1;
      drive(0, 0, 0);
      repeat (n) tick();
      reset = 1'b0;
      sbq.delete();
      pend_fv = 1'b0;
   endtask

   task automatic chk_idle(input string tag);
      check({tag, "_fpu_valid"}, {31'd0, fpu_valid}, 32'd0);
      check({tag, "_fpu_a"}, fpu_a, 32'd0);
      check({tag, "_fpu_b"}, fpu_b, 32'd0);
      check({tag, "_res_valid"}, {31'd0, res_valid}, 32'd0);
      check({tag, "_res_id"}, {31'd0, res_id}, 32'd0);
      check({tag, "_res_data"}, res_data, 32'd0);
      check({tag, "_drain_done"}, {31'd0, drain_done}, 32'd0);
      check({tag, "_busy"}, {31'd0, busy}, 32'd0);
   endtask

   task automatic flush();
      drive(0, 0, 0);
      for (int i = 0; i < STAGES + 6 && sbq.size() > 0; i++) tick();
      check("flush_empty", sbq.size(), 32'd0);
      tick();
   endtask

   initial begin
      bit got_done;
      checks = 0; errors = 0; cyc = 0; last_res_cyc = -100;
      pend_fv = 1'b0; chk_rdy = 1'b0;
      reset = 1'b1;
      drive(0, 0, 0);

      // arbitration vectors from reset (req0 favoured first)
      vecs[0]  = '{v0: 1, v1: 0, r0: 1, r1: 0};
      vecs[1]  = '{v0: 1, v1: 1, r0: 0, r1: 1};
      vecs[2]  = '{v0: 1, v1: 1, r0: 1, r1: 0};
      vecs[3]  = '{v0: 1, v1: 1, r0: 0, r1: 1};
      vecs[4]  = '{v0: 0, v1: 0, r0: 0, r1: 0};
      vecs[5]  = '{v0: 0, v1: 1, r0: 0, r1: 1};
      vecs[6]  = '{v0: 1, v1: 1, r0: 1, r1: 0};
      vecs[7]  = '{v0: 1, v1: 0, r0: 1, r1: 0};
      vecs[8]  = '{v0: 1, v1: 1, r0: 0, r1: 1};
      vecs[9]  = '{v0: 0, v1: 1, r0: 0, r1: 1};
      vecs[10] = '{v0: 1, v1: 1, r0: 1, r1: 0};

      do_reset(3);
      chk_idle("reset");
`ifdef AHFP_ARB_STATS_EN
      check("stat_issue0_rst", {28'd0, stat_issue0}, 32'd0);
      check("stat_conflict_rst", {28'd0, stat_conflict}, 32'd0);
`endif

      for (int i = 0; i < 11; i++) begin
         drive(vecs[i].v0, vecs[i].v1, 0);
         if (i == 0) begin
            req0_a = 32'h3F80_0000;
            req0_b = 32'h4000_0000;
         end
         expect_ready(vecs[i].r0, vecs[i].r1);
         tick();
      end
      flush();

      // sustained contention: last table grant was req0, so req1 leads
      for (int i = 0; i < 8; i++) begin
         drive(1, 1, 0);
         expect_ready(i % 2 == 1, i % 2 == 0);
         tick();
      end
      flush();

      // drain: the drain_req cycle still accepts, the next one does not
      for (int i = 0; i < 4; i++) begin
         drive(1, 0, 0);
         tick();
      end
      drive(1, 0, 1);
      expect_ready(1, 0);
      tick();
      drive(1, 0, 1);
      expect_ready(0, 0);
      tick();
      drive(0, 0, 1);
      got_done = 1'b0;
      for (int i = 0; i < 40 && !got_done; i++) begin
         tick();
         got_done = drain_done;
      end
      check("drain_done_seen", {31'd0, got_done}, 32'd1);
      check("drain_done_timing", cyc, last_res_cyc + 1);
      check("drain_results_out", sbq.size(), 32'd0);
      drive(1, 0, 0);
      expect_ready(0, 0);
      tick();
      check("run_resumed_done", {31'd0, drain_done}, 32'd0);
      drive(1, 0, 0);
      expect_ready(1, 0);
      tick();
      flush();

      // reset with three operations in flight
      for (int i = 0; i < 3; i++) begin
         drive(i % 2 == 0, i % 2 == 1, 0);
         tick();
      end
      drive(0, 0, 0);
      tick();
      tick();
      do_reset(1);
      chk_idle("midreset");
      for (int i = 0; i < STAGES + 4; i++) begin
         tick();
         check("post_reset_res_valid", {31'd0, res_valid}, 32'd0);
      end

`ifdef AHFP_ARB_STATS_EN
      for (int i = 0; i < 20; i++) begin
         drive(1, 1, 0);
         tick();
      end
      drive(0, 0, 0);
      check("stat_conflict_sat", {28'd0, stat_conflict}, 32'hF);
      check("stat_issue0", {28'd0, stat_issue0}, 32'd10);
      check("stat_issue1", {28'd0, stat_issue1}, 32'd10);
      flush();
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
